// File: rtl/layer_drain_if.sv
// Activation input stream and drained result stream of layer_drain.
interface layer_drain_if #(
    parameter int unsigned SIZE  = 100,
    parameter int unsigned OUT_W = 16
);
    localparam int unsigned IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;

    logic                     in_valid;
    logic                     in_ready;
    logic signed [31:0]       in_data;
    logic                     in_last;

    logic                     out_valid;
    logic                     out_ready;
    logic signed [OUT_W-1:0]  out_data;
    logic [IDX_W-1:0]         out_index;
    logic                     out_last;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_index, out_last
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_index, out_last
    );
endinterface

// File: rtl/layer_drain.sv
// Layer sequencer for a systolic accumulator row: feeds activations, flushes the
// pipeline, snapshots the accumulators, clears the array and drains quantised words.
module layer_drain #(
    parameter int unsigned SIZE  = 100,
    parameter int unsigned OUT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [4:0]         cfg_shift,
    input  logic               cfg_relu,
    output logic signed [31:0] array_in,
    output logic               array_rst_n,
    input  logic signed [31:0] acc_in [SIZE],
    output logic               busy,
    layer_drain_if.slave       bus
);
    localparam int unsigned       IDX_W    = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(SIZE - 1);
    localparam logic signed [31:0] SAT_MAX = 32'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [31:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCUM,
        S_FLUSH,
        S_CAPTURE,
        S_DRAIN
    } state_t;

    state_t                  r_state;
    logic [IDX_W-1:0]        r_flush_cnt;
    logic [IDX_W-1:0]        r_out_index;
    logic signed [31:0]      r_snap [SIZE];
    logic [4:0]              r_shift;
    logic                    r_relu;
    logic                    r_out_valid;
    logic signed [OUT_W-1:0] r_out_data;
    logic                    r_out_last;
    logic                    r_in_ready;
    logic                    r_busy;

    state_t                  w_state_nxt;
    logic [IDX_W-1:0]        w_flush_cnt_nxt;
    logic [IDX_W-1:0]        w_out_index_nxt;
    logic [IDX_W-1:0]        w_idx_inc;
    logic signed [OUT_W-1:0] w_out_data_nxt;
    logic                    w_ld_cfg;
    logic                    w_in_acc;
    logic                    w_out_acc;

    // Shift (floor), optional ReLU, then clamp into the signed output range.
    function automatic logic signed [OUT_W-1:0] f_convert(
        input logic signed [31:0] v,
        input logic [4:0]         sh,
        input logic               relu
    );
        logic signed [31:0] s;
        s = v >>> sh;
        if (relu && s[31]) s = '0;
        if (s > SAT_MAX)      s = SAT_MAX;
        else if (s < SAT_MIN) s = SAT_MIN;
        return OUT_W'(s);
    endfunction

    assign w_in_acc  = bus.in_valid & r_in_ready;
    assign w_out_acc = r_out_valid & bus.out_ready;
    assign w_idx_inc = r_out_index + 1'b1;

    assign array_in    = w_in_acc ? bus.in_data : '0;
    assign array_rst_n = ~(rst | (r_state == S_CAPTURE));

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_index = r_out_index;
    assign bus.out_last  = r_out_last;
    assign busy          = r_busy;

    // Next-state and next-output decode.
    always_comb begin
        w_state_nxt     = r_state;
        w_flush_cnt_nxt = r_flush_cnt;
        w_out_index_nxt = r_out_index;
        w_out_data_nxt  = r_out_data;
        w_ld_cfg        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_ACCUM;
                    w_ld_cfg    = 1'b1;
                end
            end
            S_ACCUM: begin
                if (w_in_acc && bus.in_last) begin
                    w_state_nxt     = S_FLUSH;
                    w_flush_cnt_nxt = '0;
                end
            end
            S_FLUSH: begin
                if (r_flush_cnt == LAST_IDX) begin
                    w_state_nxt     = S_CAPTURE;
                    w_flush_cnt_nxt = '0;
                end else begin
                    w_flush_cnt_nxt = r_flush_cnt + 1'b1;
                end
            end
            S_CAPTURE: begin
                // Word 0 is converted straight from the array as the snapshot is taken.
                w_state_nxt     = S_DRAIN;
                w_out_index_nxt = '0;
                w_out_data_nxt  = f_convert(acc_in[0], r_shift, r_relu);
            end
            S_DRAIN: begin
                if (w_out_acc) begin
                    if (r_out_index == LAST_IDX) begin
                        w_state_nxt     = S_IDLE;
                        w_out_index_nxt = '0;
                        w_out_data_nxt  = '0;
                    end else begin
                        w_out_index_nxt = w_idx_inc;
                        w_out_data_nxt  = f_convert(r_snap[w_idx_inc], r_shift, r_relu);
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State, counters, config and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_flush_cnt <= '0;
            r_out_index <= '0;
            r_shift     <= '0;
            r_relu      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_in_ready  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
            r_out_index <= w_out_index_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_valid <= (w_state_nxt == S_DRAIN);
            r_out_last  <= (w_state_nxt == S_DRAIN) && (w_out_index_nxt == LAST_IDX);
            r_in_ready  <= (w_state_nxt == S_ACCUM);
            r_busy      <= (w_state_nxt != S_IDLE);
            if (w_ld_cfg) begin
                r_shift <= cfg_shift;
                r_relu  <= cfg_relu;
            end
        end
    end

    // Accumulator snapshot taken in the single CAPTURE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(SIZE); i++) r_snap[i] <= '0;
        end else if (r_state == S_CAPTURE) begin
            for (int i = 0; i < int'(SIZE); i++) r_snap[i] <= acc_in[i];
        end
    end
endmodule

// File: tb/tb_layer_drain.sv
// Self-checking bench for layer_drain with a 4-column behavioural array (weights 1..4).
module tb_layer_drain;
    localparam int SIZE  = 4;
    localparam int OUT_W = 16;

    typedef struct {
        logic signed [15:0] data;
        logic [1:0]         idx;
        logic               last;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic [4:0]         cfg_shift = '0;
    logic               cfg_relu = 1'b0;
    logic signed [31:0] array_in;
    logic               array_rst_n;
    logic signed [31:0] acc_arr [SIZE];
    logic               busy;

    layer_drain_if #(.SIZE(SIZE), .OUT_W(OUT_W)) bus ();

    layer_drain #(.SIZE(SIZE), .OUT_W(OUT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .cfg_shift   (cfg_shift),
        .cfg_relu    (cfg_relu),
        .array_in    (array_in),
        .array_rst_n (array_rst_n),
        .acc_in      (acc_arr),
        .busy        (busy),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   n_acc    = 0;
    int   n_clr    = 0;
    exp_t sb[$];
    int   beat_q[$];

    // Behavioural systolic row: value enters column 0, moves one column per cycle.
    logic signed [31:0] pipe [SIZE];
    int                 wgt  [SIZE] = '{1, 2, 3, 4};
    initial for (int i = 0; i < SIZE; i++) begin acc_arr[i] = '0; pipe[i] = '0; end
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!array_rst_n) begin
            for (int i = 0; i < SIZE; i++) begin acc_arr[i] <= '0; pipe[i] <= '0; end
        end else begin
            acc_arr[0] <= acc_arr[0] + array_in * wgt[0];
            pipe[0]    <= array_in;
            for (int i = 1; i < SIZE; i++) begin
                acc_arr[i] <= acc_arr[i] + pipe[i-1] * wgt[i];
                pipe[i]    <= pipe[i-1];
            end
        end
    end

    // Scoreboard consumer: every accepted output word is matched against the queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (!array_rst_n) n_clr++;
            if (bus.out_valid && bus.out_ready) begin
                n_acc++;
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL word_unexpected got data=%0d index=%0d", bus.out_data, bus.out_index);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (bus.out_data !== e.data || bus.out_index !== e.idx || bus.out_last !== e.last) begin
                        failures++;
                        $display("FAIL word got data=%0d index=%0d last=%0b expected data=%0d index=%0d last=%0b",
                                 bus.out_data, bus.out_index, bus.out_last, e.data, e.idx, e.last);
                    end
                end
            end
        end
    end

    function automatic logic signed [15:0] model_word(longint v, int sh, bit relu);
        longint s;
        s = v >>> sh;
        if (relu && s < 0) s = 0;
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
        return 16'(s);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pushes expected words, pulses start, then streams beat_q; returns the cycle of the last beat.
    task automatic send_layer(input int sh, input bit relu, output int last_cyc);
        longint sum = 0;
        foreach (beat_q[i]) sum += beat_q[i];
        for (int i = 0; i < SIZE; i++) begin
            exp_t e;
            e.data = model_word(sum * wgt[i], sh, relu);
            e.idx  = 2'(i);
            e.last = (i == SIZE - 1);
            sb.push_back(e);
        end
        last_cyc  = 0;
        cfg_shift = 5'(sh);
        cfg_relu  = relu;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        cfg_shift = '0;
        cfg_relu  = 1'b0;
        for (int i = 0; i < beat_q.size(); i++) begin
            int g = 0;
            bus.in_valid = 1'b1;
            bus.in_data  = beat_q[i];
            bus.in_last  = (i == beat_q.size() - 1);
            while (!bus.in_ready && g < 20) begin tick(); g++; end
            if (g >= 20) begin
                checks++; failures++;
                $display("FAIL in_ready_timeout got in_ready=%0b expected 1", bus.in_ready);
            end
            last_cyc = cyc;
            tick();
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_data  = '0;
    endtask

    task automatic wait_idle();
        int g = 0;
        while (busy && g < 100) begin tick(); g++; end
        if (g >= 100) begin
            checks++; failures++;
            $display("FAIL idle_timeout got busy=%0b expected 0", busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        checks++;
        if (busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.out_last !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags got busy=%0b out_valid=%0b in_ready=%0b out_last=%0b expected 0 0 0 0",
                     busy, bus.out_valid, bus.in_ready, bus.out_last);
        end
        checks++;
        if (bus.out_data !== 16'sd0 || bus.out_index !== 2'd0) begin
            failures++;
            $display("FAIL reset_data got out_data=%0d out_index=%0d expected 0 0", bus.out_data, bus.out_index);
        end
        checks++;
        if (array_rst_n !== 1'b0) begin
            failures++;
            $display("FAIL reset_array_rst_n got %0b expected 0", array_rst_n);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (array_rst_n !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL post_reset got array_rst_n=%0b busy=%0b expected 1 0", array_rst_n, busy);
        end
    endtask

    task automatic test_basic();
        int lc;
        int g = 0;
        n_acc = 0; n_clr = 0;
        bus.out_ready = 1'b1;
        beat_q = '{5, 6, 7};
        send_layer(1, 1'b0, lc);
        while (!bus.out_valid && g < 30) begin tick(); g++; end
        checks++;
        if (cyc - lc !== SIZE + 2) begin
            failures++;
            $display("FAIL latency got %0d cycles expected %0d", cyc - lc, SIZE + 2);
        end
        wait_idle();
        tick();
        checks++;
        if (n_acc !== 4 || n_clr !== 1 || sb.size() !== 0) begin
            failures++;
            $display("FAIL basic_counts got words=%0d clears=%0d pending=%0d expected 4 1 0", n_acc, n_clr, sb.size());
        end
    endtask

    task automatic test_back_pressure();
        int lc;
        int g = 0;
        n_acc = 0;
        bus.out_ready = 1'b1;
        beat_q = '{5, 6, 7};
        send_layer(1, 1'b0, lc);
        while (!(bus.out_valid && bus.out_index == 2'd1) && g < 40) begin tick(); g++; end
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 16'sd18 || bus.out_index !== 2'd1) begin
                failures++;
                $display("FAIL stall_hold got valid=%0b data=%0d index=%0d expected 1 18 1",
                         bus.out_valid, bus.out_data, bus.out_index);
            end
            tick();
        end
        bus.out_ready = 1'b1;
        wait_idle();
        tick();
        checks++;
        if (n_acc !== 4 || sb.size() !== 0) begin
            failures++;
            $display("FAIL stall_count got words=%0d pending=%0d expected 4 0", n_acc, sb.size());
        end
    endtask

    task automatic test_sat_relu();
        int lc;
        bus.out_ready = 1'b1;
        beat_q = '{25000};
        send_layer(0, 1'b0, lc); wait_idle();
        beat_q = '{-25000};
        send_layer(0, 1'b0, lc); wait_idle();
        beat_q = '{-25000};
        send_layer(0, 1'b1, lc); wait_idle();
        tick();
        checks++;
        if (sb.size() !== 0) begin
            failures++;
            $display("FAIL sat_pending got %0d expected 0", sb.size());
        end
    endtask

    task automatic test_clear();
        int lc;
        bus.out_ready = 1'b1;
        for (int l = 0; l < 2; l++) begin
            n_clr = 0;
            beat_q = '{1};
            send_layer(0, 1'b0, lc);
            wait_idle();
            tick();
            checks++;
            if (n_clr !== 1) begin
                failures++;
                $display("FAIL clear_pulses layer=%0d got %0d expected 1", l, n_clr);
            end
        end
    endtask

    task automatic test_gating();
        int lc;
        int g = 0;
        bus.out_ready = 1'b1;
        beat_q = '{3, 4};
        send_layer(0, 1'b0, lc);
        bus.in_valid = 1'b1;
        bus.in_data  = 99;
        while (busy && g < 40) begin
            checks++;
            if (bus.in_ready !== 1'b0 || array_in !== 32'sd0) begin
                failures++;
                $display("FAIL gating got in_ready=%0b array_in=%0d expected 0 0", bus.in_ready, array_in);
            end
            if (bus.out_valid) start = 1'b1;
            tick();
            g++;
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL start_in_drain got busy=%0b expected 0", busy);
        end
        start = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        tick();
        checks++;
        if (busy !== 1'b0 || sb.size() !== 0) begin
            failures++;
            $display("FAIL gating_end got busy=%0b pending=%0d expected 0 0", busy, sb.size());
        end
    endtask

    task automatic test_reset_mid_drain();
        int lc;
        int g = 0;
        bus.out_ready = 1'b1;
        beat_q = '{5, 6, 7};
        send_layer(1, 1'b0, lc);
        while (!(bus.out_valid && bus.out_index == 2'd2) && g < 40) begin tick(); g++; end
        rst = 1'b1;
        #1;
        checks++;
        if (array_rst_n !== 1'b0) begin
            failures++;
            $display("FAIL rst_array_clear got %0b expected 0", array_rst_n);
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.out_index !== 2'd0 || bus.out_data !== 16'sd0) begin
            failures++;
            $display("FAIL rst_mid_drain got valid=%0b busy=%0b index=%0d data=%0d expected 0 0 0 0",
                     bus.out_valid, busy, bus.out_index, bus.out_data);
        end
        rst = 1'b0;
        sb.delete();
        tick();
        beat_q = '{2, 3};
        send_layer(0, 1'b0, lc);
        wait_idle();
        tick();
        checks++;
        if (sb.size() !== 0) begin
            failures++;
            $display("FAIL after_rst_pending got %0d expected 0", sb.size());
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_back_pressure();
        test_sat_relu();
        test_clear();
        test_gating();
        test_reset_mid_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end
endmodule

// File: doc/layer_drain.md
LAYER_DRAIN -- requirements
Module: layer_drain

Interface
REQ-001 The block SHALL have parameter SIZE, default 100, meaning the number of systolic columns (accumulators).
REQ-002 The block SHALL have parameter OUT_W, default 16, meaning the signed width of each drained output word.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: begins a layer; honoured only in IDLE.
REQ-006 The block SHALL have port cfg_shift, input, 5 bits: arithmetic right-shift amount, latched on an accepted start.
REQ-007 The block SHALL have port cfg_relu, input, 1 bit: ReLU enable, latched on an accepted start.
REQ-008 The block SHALL have ports in_valid (input, 1), in_ready (output, 1), in_data (input, 32, signed) and in_last (input, 1): the activation stream, with in_last marking the final beat.
REQ-009 The block SHALL have port array_in, output, 32 bits, signed: the value driven to the array's input_weight.
REQ-010 The block SHALL have port array_rst_n, output, 1 bit: active-low clear driven to the array's rst_n.
REQ-011 The block SHALL have port acc_in, input, SIZE x 32 bits, signed: the array's output_weight vector.
REQ-012 The block SHALL have ports out_valid (output, 1), out_ready (input, 1), out_data (output, OUT_W, signed), out_index (output, clog2(SIZE)) and out_last (output, 1): the drained result stream.
REQ-013 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-014 States SHALL be IDLE, ACCUM, FLUSH, CAPTURE and DRAIN.
REQ-015 IDLE SHALL move to ACCUM on start; cfg_shift and cfg_relu SHALL be latched on that edge.
REQ-016 In ACCUM, in_ready SHALL be 1; in_ready SHALL be 0 in every other state.
REQ-017 A beat SHALL be accepted when in_valid and in_ready are both 1.
REQ-018 array_in SHALL equal in_data when a beat is accepted, and 0 otherwise (combinational, all states).
REQ-019 An accepted beat with in_last=1 SHALL move the block to FLUSH; a layer always has at least one beat.
REQ-020 FLUSH SHALL last exactly SIZE cycles, counted by an internal counter, so the last beat reaches column SIZE-1; the block then moves to CAPTURE.
REQ-021 CAPTURE SHALL last one cycle:
- latch all SIZE acc_in values into a snapshot register;
- drive array_rst_n=0 in that cycle only;
- then move to DRAIN.
REQ-022 array_rst_n SHALL be 1 in all other cycles, except while rst=1 (see REQ-029).
REQ-023 DRAIN SHALL present snapshot words in index order 0..SIZE-1:
- out_valid=1 throughout DRAIN;
- the index advances only on out_valid and out_ready;
- out_data and out_index SHALL hold stable while stalled.
REQ-024 out_last SHALL be 1 exactly when out_index=SIZE-1 in DRAIN; acceptance of that word SHALL return the block to IDLE.
REQ-025 The conversion to out_data SHALL be, in order:
- s = snapshot >>> shift (arithmetic, floor);
- if relu, s = max(s, 0);
- saturate s to the signed OUT_W range [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-026 out_data SHALL be driven from registered state, with no combinational path from out_ready.
REQ-027 start SHALL be ignored in every state except IDLE, including when it coincides with a DRAIN completion.
REQ-028 The minimum latency from the in_last beat to the first out_valid SHALL be SIZE+2 cycles.

Reset
REQ-029 While rst=1 the block SHALL drive array_rst_n=0, so the array clears in step.
REQ-030 On rst=1 at any state, including mid-ACCUM or mid-DRAIN, the next state SHALL be IDLE with:
- counters = 0, snapshot = 0, latched config = 0;
- out_valid = 0, out_data = 0, out_index = 0, out_last = 0, in_ready = 0, busy = 0;
- any in-flight layer discarded.

Verification (SIZE=4, OUT_W=16, array net_weight={1,2,3,4})
REQ-031 Basic layer: start, shift=1, relu=0, beats 5, 6, 7(last), out_ready=1 -> out_data 9, 18, 27, 36; out_last only on index 3; first out_valid 6 cycles after the last beat.
REQ-032 Back-pressure: same layer with out_ready held 0 for 3 cycles at index 1 -> out_data=18 and out_index=1 held stable; total of exactly 4 words accepted.
REQ-033 Saturation/ReLU: single beat 25000(last), shift=0 -> words 25000, 32767, 32767, 32767; single beat -25000, relu=0 -> -25000, -32768, -32768, -32768; relu=1 -> all 0.
REQ-034 Array clear: two consecutive layers, each a single beat 1 with shift=0 -> second layer drains 1, 2, 3, 4, not accumulated; array_rst_n low for exactly one cycle per layer.
REQ-035 Input gating: in_valid=1 during FLUSH, CAPTURE and DRAIN -> in_ready=0 and array_in=0; start pulsed during DRAIN is ignored.
REQ-036 Reset mid-DRAIN at index 2 -> next cycle IDLE, out_valid=0, array_rst_n=0 during rst; a new layer afterwards drains correct values.
